// File: rtl/text_mode_pkg.sv
// Shared text-mode definitions: screen geometry widths and RAM access tags.
package text_mode_pkg;

  localparam int unsigned SCREEN_ADDR_W = 11;
  localparam int unsigned CHR_W         = 8;

  typedef enum logic [1:0] {
    TAG_NONE    = 2'd0,
    TAG_DISP    = 2'd1,
    TAG_HOST_RD = 2'd2
  } tag_t;

  // Host writes produce no return data, so they carry no tag.
  function automatic tag_t host_tag(input logic we);
    return we ? TAG_NONE : TAG_HOST_RD;
  endfunction

endpackage

// File: rtl/ram_tag_pipe.sv
// Tag shift register tracking who owns each in-flight RAM read.
module ram_tag_pipe
  import text_mode_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_issue,
  output tag_t tag_ret
);

  tag_t stage_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= TAG_NONE;
    end else begin
      stage_q[0] <= tag_issue;
      for (int unsigned i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tag_ret = stage_q[DEPTH-1];

endmodule

// File: rtl/screen_ram_arbiter.sv
// Screen RAM arbiter: display fetches take every cycle they ask for, host
// accesses fill the gaps; returning data is routed by the tag pipeline.
module screen_ram_arbiter
  import text_mode_pkg::*;
#(
  parameter int unsigned ADDR_W       = SCREEN_ADDR_W,
  parameter int unsigned DATA_W       = CHR_W,
  parameter int unsigned RAM_LAT      = 1,
  parameter int unsigned HOST_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_req_i,
  input  logic [ADDR_W-1:0] disp_addr_i,
  output logic [DATA_W-1:0] disp_data_o,
  output logic              disp_valid_o,
  input  logic              host_req_i,
  input  logic              host_we_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [DATA_W-1:0] host_wdata_i,
  output logic              host_ack_o,
  output logic [DATA_W-1:0] host_rdata_o,
  output logic              host_rvalid_o,
  output logic              host_stall_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_data_o,
  output logic              ram_wren_o,
  input  logic [DATA_W-1:0] ram_q_i
);

  localparam int unsigned WAIT_W = $clog2(HOST_TIMEOUT + 1);

  if (RAM_LAT < 1 || RAM_LAT > 3) begin : g_bad_lat
    $error("screen_ram_arbiter: RAM_LAT must be 1..3");
  end

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [WAIT_W-1:0] wait_q;
  logic [WAIT_W-1:0] wait_d;
  tag_t              issue_tag;
  tag_t              ret_tag;

  // Grant mux; gated by rst so every output reads 0 while reset is held.
  always_comb begin
    ram_addr_o = addr_q;
    ram_data_o = wdata_q;
    ram_wren_o = 1'b0;
    host_ack_o = 1'b0;
    issue_tag  = TAG_NONE;
    if (!rst) begin
      if (disp_req_i) begin
        ram_addr_o = disp_addr_i;
        issue_tag  = TAG_DISP;
      end else if (host_req_i) begin
        ram_addr_o = host_addr_i;
        ram_data_o = host_wdata_i;
        ram_wren_o = host_we_i;
        host_ack_o = 1'b1;
        issue_tag  = host_tag(host_we_i);
      end
    end
  end

  // Host wait counter, saturating at the timeout.
  always_comb begin
    wait_d = wait_q;
    if (!host_req_i || host_ack_o) begin
      wait_d = '0;
    end else if (wait_q != WAIT_W'(HOST_TIMEOUT)) begin
      wait_d = wait_q + WAIT_W'(1);
    end
  end

  ram_tag_pipe #(
    .DEPTH (RAM_LAT)
  ) u_tag_pipe (
    .clk       (clk),
    .rst       (rst),
    .tag_issue (issue_tag),
    .tag_ret   (ret_tag)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q        <= '0;
      wdata_q       <= '0;
      wait_q        <= '0;
      host_stall_o  <= 1'b0;
      disp_data_o   <= '0;
      disp_valid_o  <= 1'b0;
      host_rdata_o  <= '0;
      host_rvalid_o <= 1'b0;
    end else begin
      addr_q        <= ram_addr_o;
      wdata_q       <= ram_data_o;
      wait_q        <= wait_d;
      if (wait_d == WAIT_W'(HOST_TIMEOUT)) host_stall_o <= 1'b1;
      disp_valid_o  <= (ret_tag == TAG_DISP);
      host_rvalid_o <= (ret_tag == TAG_HOST_RD);
      if (ret_tag == TAG_DISP)    disp_data_o  <= ram_q_i;
      if (ret_tag == TAG_HOST_RD) host_rdata_o <= ram_q_i;
    end
  end

endmodule

// File: tb/tb_screen_ram_arbiter.sv
// Bench for screen_ram_arbiter: two builds (RAM_LAT=1 and 2) share one stimulus
// stream; a reference grant/stall model and per-build return scoreboards check them.
module tb_screen_ram_arbiter;

  localparam int unsigned AW = 11;
  localparam int unsigned DW = 8;
  localparam int          LAT0 = 1;
  localparam int          LAT1 = 2;
  localparam int          TMO  = 64;

  typedef struct packed {
    logic [DW-1:0] d;
    int            due;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic boot;
  logic disp_req;
  logic [AW-1:0] disp_addr;
  logic host_req;
  logic host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;

  logic [DW-1:0] dd [2];
  logic [DW-1:0] hd [2];
  logic [AW-1:0] ra [2];
  logic [DW-1:0] rw [2];
  logic [1:0] dv, hv, ack, stall, wren;
  logic [DW-1:0] q0, q1a, q1b;

  logic [DW-1:0] mem0 [2048];
  logic [DW-1:0] mem1 [2048];
  logic [DW-1:0] ref_mem [2048];

  exp_t dq [2][$];
  exp_t hq [2][$];
  logic [DW-1:0] m_dd [2];
  logic [DW-1:0] m_hd [2];
  logic [AW-1:0] last_addr;
  logic [DW-1:0] last_data;
  int m_wait;
  logic m_stall;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  logic done;
  logic final_done = 1'b0;
  int tmo_hits;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  screen_ram_arbiter #(.RAM_LAT(LAT0), .HOST_TIMEOUT(TMO)) u_lat1 (
    .clk(clk), .rst(rst),
    .disp_req_i(disp_req), .disp_addr_i(disp_addr),
    .disp_data_o(dd[0]), .disp_valid_o(dv[0]),
    .host_req_i(host_req), .host_we_i(host_we), .host_addr_i(host_addr),
    .host_wdata_i(host_wdata), .host_ack_o(ack[0]), .host_rdata_o(hd[0]),
    .host_rvalid_o(hv[0]), .host_stall_o(stall[0]),
    .ram_addr_o(ra[0]), .ram_data_o(rw[0]), .ram_wren_o(wren[0]), .ram_q_i(q0)
  );

  screen_ram_arbiter #(.RAM_LAT(LAT1), .HOST_TIMEOUT(TMO)) u_lat2 (
    .clk(clk), .rst(rst),
    .disp_req_i(disp_req), .disp_addr_i(disp_addr),
    .disp_data_o(dd[1]), .disp_valid_o(dv[1]),
    .host_req_i(host_req), .host_we_i(host_we), .host_addr_i(host_addr),
    .host_wdata_i(host_wdata), .host_ack_o(ack[1]), .host_rdata_o(hd[1]),
    .host_rvalid_o(hv[1]), .host_stall_o(stall[1]),
    .ram_addr_o(ra[1]), .ram_data_o(rw[1]), .ram_wren_o(wren[1]), .ram_q_i(q1b)
  );

  function automatic logic [DW-1:0] init_val(input int a);
    logic [AW-1:0] x;
    x = AW'(a);
    return x[7:0] ^ 8'h5A ^ {x[10:8], 5'b0};
  endfunction

  // Single-port read-new-data RAMs with 1- and 2-cycle read latency.
  always @(posedge clk) begin
    if (boot) begin
      for (int a = 0; a < 2048; a++) begin
        mem0[a] <= init_val(a);
        mem1[a] <= init_val(a);
      end
    end else begin
      if (wren[0]) mem0[ra[0]] <= rw[0];
      if (wren[1]) mem1[ra[1]] <= rw[1];
    end
    q0  <= wren[0] ? rw[0] : mem0[ra[0]];
    q1a <= wren[1] ? rw[1] : mem1[ra[1]];
    q1b <= q1a;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model and scoreboards, sampled on the falling edge.
  always @(negedge clk) begin
    logic ma;
    logic [AW-1:0] maddr;
    logic [DW-1:0] mdat;
    exp_t e;
    int lat;
    if (boot) for (int a = 0; a < 2048; a++) ref_mem[a] = init_val(a);
    ma    = !rst && host_req && !disp_req;
    maddr = rst ? '0 : disp_req ? disp_addr : ma ? host_addr : last_addr;
    mdat  = rst ? '0 : ma ? host_wdata : last_data;
    if (rst) begin
      m_wait  = 0;
      m_stall = 1'b0;
      for (int i = 0; i < 2; i++) begin
        dq[i].delete();
        hq[i].delete();
        m_dd[i] = '0;
        m_hd[i] = '0;
      end
    end
    for (int i = 0; i < 2; i++) begin
      lat = (i == 0) ? LAT0 : LAT1;
      chk("host_ack", 32'(ack[i]), 32'(ma));
      chk("ram_wren", 32'(wren[i]), 32'(ma && host_we));
      chk("ram_addr", 32'(ra[i]), 32'(maddr));
      chk("ram_data", 32'(rw[i]), 32'(mdat));
      chk("host_stall", 32'(stall[i]), 32'(m_stall));
      if (dq[i].size() != 0 && dq[i][0].due < cyc) begin
        e = dq[i].pop_front();
        chk("disp_missing", 32'(cyc), 32'(e.due));
      end
      if (dv[i]) begin
        if (dq[i].size() == 0) chk("disp_spurious", 32'(dv[i]), 32'(0));
        else begin
          e = dq[i].pop_front();
          chk("disp_cycle", 32'(cyc), 32'(e.due));
          m_dd[i] = e.d;
        end
      end
      chk("disp_data", 32'(dd[i]), 32'(m_dd[i]));
      if (hq[i].size() != 0 && hq[i][0].due < cyc) begin
        e = hq[i].pop_front();
        chk("host_missing", 32'(cyc), 32'(e.due));
      end
      if (hv[i]) begin
        if (hq[i].size() == 0) chk("host_spurious", 32'(hv[i]), 32'(0));
        else begin
          e = hq[i].pop_front();
          chk("host_cycle", 32'(cyc), 32'(e.due));
          m_hd[i] = e.d;
        end
      end
      chk("host_rdata", 32'(hd[i]), 32'(m_hd[i]));
      if (!rst && disp_req) dq[i].push_back('{d: ref_mem[disp_addr], due: cyc + lat + 1});
      if (ma && !host_we)   hq[i].push_back('{d: ref_mem[host_addr], due: cyc + lat + 1});
      if (done && !final_done) begin
        chk("disp_drain", 32'(dq[i].size()), 32'(0));
        chk("host_drain", 32'(hq[i].size()), 32'(0));
      end
    end
    if (done && !final_done) begin
      chk("ack_timeouts", 32'(tmo_hits), 32'(0));
      final_done = 1'b1;
    end
    if (ma && host_we) ref_mem[host_addr] = host_wdata;
    last_addr = maddr;
    last_data = mdat;
    if (!rst) begin
      if (!host_req || ma) m_wait = 0;
      else if (m_wait != TMO) m_wait++;
      if (m_wait == TMO) m_stall = 1'b1;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Host handshake: hold request until acked (bounded), drop it after the ack edge.
  task automatic host_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    n = 0;
    host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
    @(negedge clk);
    while (!ack[0] && n < 200) begin
      @(posedge clk); #1;
      @(negedge clk);
      n++;
    end
    if (n >= 200) tmo_hits++;
    @(posedge clk); #1;
    host_req = 1'b0;
  endtask

  task automatic disp_fetch(input logic [AW-1:0] a);
    disp_req = 1'b1; disp_addr = a;
    @(posedge clk); #1;
    disp_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tmo_hits = 0;
    done = 1'b0;
    rst = 1'b1; boot = 1'b1;
    disp_req = 1'b0; disp_addr = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    idle(3);
    boot = 1'b0; rst = 1'b0;
    idle(1);
    // host write then read, then back-to-back read-after-write
    host_op(1'b1, 11'h123, 8'h41);
    host_op(1'b0, 11'h123, 8'h00);
    host_op(1'b1, 11'h124, 8'h77);
    host_op(1'b0, 11'h124, 8'h00);
    host_op(1'b1, 11'h200, 8'h99);
    disp_fetch(11'h200);
    idle(3);
    // collision: display wins, host acked the following cycle
    host_req = 1'b1; host_we = 1'b0; host_addr = 11'h020;
    disp_req = 1'b1; disp_addr = 11'h010;
    idle(1);
    disp_req = 1'b0;
    idle(1);
    host_req = 1'b0;
    idle(4);
    // starvation: 70-cycle display burst against a pending host read
    host_req = 1'b1; host_we = 1'b0; host_addr = 11'h055;
    for (int k = 0; k < 70; k++) begin
      disp_req = 1'b1; disp_addr = AW'(k);
      idle(1);
    end
    disp_req = 1'b0;
    idle(1);
    host_req = 1'b0;
    idle(4);
    // reset pulsed the cycle after a host read is acked
    host_req = 1'b1; host_we = 1'b0; host_addr = 11'h123;
    idle(1);
    host_req = 1'b0; rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(5);
    // alternating display/host reads over 32 addresses
    for (int i = 0; i < 32; i++) begin
      host_req = 1'b0; disp_req = 1'b1; disp_addr = AW'(11'h300 + i);
      idle(1);
      disp_req = 1'b0; host_req = 1'b1; host_we = 1'b0; host_addr = AW'(11'h400 + i);
      idle(1);
    end
    host_req = 1'b0;
    idle(3);
    // host write followed immediately by a display read of the same cell
    for (int i = 0; i < 8; i++) begin
      host_op(1'b1, AW'(11'h500 + i), DW'($urandom_range(0, 255)));
      disp_fetch(AW'(11'h500 + i));
    end
    idle(8);
    done = 1'b1;
    idle(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/screen_ram_arbiter.md
Name: screen_ram_arbiter

Overview:
- Shares the single-port screen RAM between the display fetch path and the host path (switch/keyboard writes and readback).
- Display fetches have absolute priority and a fixed latency, so pixel timing never jitters.
- Host accesses use a req/ack handshake and are served in cycles with no display fetch.
- A tag pipeline routes returning RAM data to the requester that issued the access.

Parameters:
- ADDR_W, 11, screen RAM address width (2048 cells)
- DATA_W, 8, character code width
- RAM_LAT, 1, RAM read latency in cycles from address issue to ram_q_i valid; legal range 1..3
- HOST_TIMEOUT, 64, consecutive cycles a host request may wait ungranted before host_stall_o sets

Ports:
- clk  in  1  pixel-domain clock (vga_clk)
- rst  in  1  asynchronous, active-high reset
- disp_req_i  in  1  display fetch request; single-cycle strobe
- disp_addr_i  in  ADDR_W  display fetch address; sampled with disp_req_i
- disp_data_o  out  DATA_W  fetched character code
- disp_valid_o  out  1  disp_data_o valid; one-cycle pulse
- host_req_i  in  1  host request; held with fields stable until host_ack_o
- host_we_i  in  1  1 = write, 0 = read
- host_addr_i  in  ADDR_W  host address
- host_wdata_i  in  DATA_W  host write data
- host_ack_o  out  1  one-cycle pulse; host access issued to RAM this cycle
- host_rdata_o  out  DATA_W  host read data
- host_rvalid_o  out  1  host_rdata_o valid; one-cycle pulse
- host_stall_o  out  1  sticky flag: host waited HOST_TIMEOUT cycles
- ram_addr_o  out  ADDR_W  RAM address
- ram_data_o  out  DATA_W  RAM write data
- ram_wren_o  out  1  RAM write enable
- ram_q_i  in  DATA_W  RAM read data

Behaviour:
- Reset (asynchronous, any time): all outputs 0, tag pipeline cleared, wait counter 0. In-flight reads are discarded and produce no valid pulses after reset releases.
- Per-cycle grant, combinational:
  - disp_req_i=1: display issued. ram_addr_o=disp_addr_i, ram_wren_o=0.
  - Else host_req_i=1: host issued. ram_addr_o=host_addr_i, ram_data_o=host_wdata_i, ram_wren_o=host_we_i, host_ack_o=1 in the same cycle.
  - Else idle: ram_wren_o=0, ram_addr_o holds its last value.
- Handshake: if host_req_i is still high in the cycle after ack, it is a new transaction. A host may therefore issue at most one access per cycle.
- Tag pipeline: RAM_LAT-stage shift register of {none, disp, host_rd}. Host writes tag none.
- When the tag reaching the last stage is disp or host_rd, ram_q_i is registered into the matching data output and its valid pulses the next cycle.
- Latency: disp_valid_o and host_rvalid_o assert exactly RAM_LAT+1 cycles after the issue cycle; with default RAM_LAT=1 this is 2 cycles.
- disp_data_o and host_rdata_o hold their value between valid pulses.
- Collision: display wins; the host waits with no ack. A display access is never delayed.
- Wait counter: counts cycles with host_req_i=1 and no ack; resets to 0 on ack or when host_req_i=0; saturates at HOST_TIMEOUT.
- host_stall_o sets when the counter reaches HOST_TIMEOUT and stays set until rst.
- Read-after-write: a host or display read issued the cycle after a write to the same address returns the new data; the RAM is read-new-data.

Decomposition:
- Shared package text_mode_pkg:
  - tag enum (TAG_NONE, TAG_DISP, TAG_HOST_RD)
  - SCREEN_ADDR_W=11 and CHR_W=8, reused by the screen RAM and the address-counter logic
- One natural sub-module, ram_tag_pipe: parameterised RAM_LAT-deep tag shift register with async reset. The grant mux, output registers and wait counter stay in the top module.

Test Plan:
- Reset: assert rst mid-stream → all outputs 0 immediately; ram_wren_o=0.
- Host write then read: write addr 0x123 data 0x41, display idle → ack and ram_wren_o=1 in the same cycle. Read 0x123 → host_rvalid_o at issue+2 with host_rdata_o=0x41.
- Collision: disp_req_i and host read requested in the same cycle, addrs 0x010 and 0x020 → display issued first, host_ack_o one cycle later. disp_valid_o at +2 with data[0x010]; host_rvalid_o at +3 with data[0x020].
- Starvation: disp_req_i held high for 70 cycles with a host request pending → host_stall_o=1 at wait cycle 64, no ack during the burst. Ack in the first cycle after the burst; stall flag stays set.
- Reset mid-flight: host read acked, rst pulsed the next cycle → no host_rvalid_o ever appears for that read.
- Interleaving: alternating display/host reads over 32 addresses, with RAM_LAT=2 and RAM_LAT=1 builds → every returned word reaches the correct requester at issue+RAM_LAT+1 with no cross-delivery.
